// File: rtl/hazard_ctl_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
package hazard_ctl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1
    } state_e;

    localparam int CNT_W      = 16;
    localparam int HOLD_W     = 8;
    localparam int HOLD_LIMIT = 255;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous reset and synchronous clear.
module sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctl.sv
// Load-use stall, branch flush and memory-hold control for a 5-stage MIPS pipeline.
// Outputs are Mealy: registered RUN/HOLD state plus the current hazard inputs.
module hazard_ctl
    import hazard_ctl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              idex_memread,
    input  logic [4:0]        idex_rt,
    input  logic [4:0]        ifid_rs,
    input  logic [4:0]        ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              exmem_br_taken,
    input  logic              mem_hold,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_flush,
    output logic              idex_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              hold_timeout,
    output logic [1:0]        state
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);

    state_e r_state;
    logic   r_br_pend;
    logic   r_hold_timeout;

    state_e w_next_state;
    logic   w_br_pend_next;
    logic   w_load_use;
    logic   w_branch;
    logic   w_stall_inc;
    logic   w_flush_inc;
    logic   w_hold_inc;
    logic   w_hold_clr;

    assign w_load_use = idex_memread && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // A branch that resolved while the pipeline was frozen is replayed on release.
    assign w_branch = exmem_br_taken || ((r_state == HOLD) && r_br_pend);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state   = RUN;
        w_br_pend_next = 1'b0;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        exmem_flush    = 1'b0;
        idex_hold      = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;
        w_hold_inc     = 1'b0;
        w_hold_clr     = 1'b0;

        if (!rst) begin
            case (r_state)
                RUN, HOLD: begin
                    if (mem_hold) begin
                        pc_write       = 1'b0;
                        ifid_write     = 1'b0;
                        idex_hold      = 1'b1;
                        w_next_state   = HOLD;
                        w_br_pend_next = exmem_br_taken || ((r_state == HOLD) && r_br_pend);
                        w_hold_inc     = (r_state == HOLD);
                    end else begin
                        w_hold_clr = (r_state == HOLD);
                        if (w_branch) begin
                            ifid_flush  = 1'b1;
                            idex_bubble = 1'b1;
                            exmem_flush = 1'b1;
                            w_flush_inc = 1'b1;
                        end else if (w_load_use) begin
                            pc_write    = 1'b0;
                            ifid_write  = 1'b0;
                            idex_bubble = 1'b1;
                            w_stall_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_br_pend      <= 1'b0;
            r_hold_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_br_pend <= w_br_pend_next;
            if (w_hold_inc && (hold_cnt >= HOLD_LAST)) begin
                r_hold_timeout <= 1'b1;
            end
        end
    end

    sat_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .clr (1'b0),
        .cnt (flush_cnt)
    );

    sat_cnt #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_hold_inc),
        .clr (w_hold_clr),
        .cnt (hold_cnt)
    );

    assign hold_timeout = r_hold_timeout;
    assign state        = r_state;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed-vector bench for hazard_ctl with hand-computed expectations.
module tb_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        exmem_br_taken;
    logic        mem_hold;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_flush;
    logic        idex_hold;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [7:0]  hold_cnt;
    logic        hold_timeout;
    logic [1:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctl dut (
        .clk            (clk),
        .rst            (rst),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rt   (ifid_uses_rt),
        .exmem_br_taken (exmem_br_taken),
        .mem_hold       (mem_hold),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .exmem_flush    (exmem_flush),
        .idex_hold      (idex_hold),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .hold_cnt       (hold_cnt),
        .hold_timeout   (hold_timeout),
        .state          (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs shortly after an edge and let the Mealy outputs settle.
    task automatic apply(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses, input logic br,
                         input logic hold);
        idex_memread   = mr;
        idex_rt        = xrt;
        ifid_rs        = rs;
        ifid_rt        = rt;
        ifid_uses_rt   = uses;
        exmem_br_taken = br;
        mem_hold       = hold;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        // Reset: hazardous inputs must not disturb the default outputs.
        apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
        check("rst_pc_write", pc_write, 1);
        check("rst_ifid_write", ifid_write, 1);
        check("rst_idex_hold", idex_hold, 0);
        check("rst_bubble", idex_bubble, 0);
        check("rst_ifid_flush", ifid_flush, 0);
        tick();
        check("rst_state", state, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_hold_cnt", hold_cnt, 0);
        check("rst_timeout", hold_timeout, 0);
        rst = 1'b0;

        // Load-use on rs: one stall cycle.
        apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_rs_pc_write", pc_write, 0);
        check("lu_rs_ifid_write", ifid_write, 0);
        check("lu_rs_bubble", idex_bubble, 1);
        check("lu_rs_flush", ifid_flush, 0);
        tick();
        check("lu_rs_stall_cnt", stall_cnt, 1);
        apply(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_after_pc_write", pc_write, 1);
        check("lu_after_bubble", idex_bubble, 0);

        // Load-use on rt when rt is a source.
        apply(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
        check("lu_rt_pc_write", pc_write, 0);
        tick();
        check("lu_rt_stall_cnt", stall_cnt, 2);

        // No stall: register 0, and rt not used as a source.
        apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("r0_pc_write", pc_write, 1);
        check("r0_bubble", idex_bubble, 0);
        apply(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
        check("rt_unused_pc_write", pc_write, 1);
        tick();
        check("no_stall_cnt", stall_cnt, 2);

        // Branch beats load-use.
        do_reset();
        apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_ifid_flush", ifid_flush, 1);
        check("br_bubble", idex_bubble, 1);
        check("br_exmem_flush", exmem_flush, 1);
        check("br_pc_write", pc_write, 1);
        tick();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 0);

        // Hold for 3 cycles with a branch in cycle 1; flush deferred to release.
        do_reset();
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("h1_pc_write", pc_write, 0);
        check("h1_ifid_write", ifid_write, 0);
        check("h1_idex_hold", idex_hold, 1);
        check("h1_ifid_flush", ifid_flush, 0);
        check("h1_exmem_flush", exmem_flush, 0);
        tick();
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("h2_state", state, 1);
        check("h2_hold_cnt", hold_cnt, 0);
        check("h2_ifid_flush", ifid_flush, 0);
        tick();
        check("h3_hold_cnt", hold_cnt, 1);
        check("h3_ifid_flush", ifid_flush, 0);
        tick();
        check("h4_hold_cnt", hold_cnt, 2);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rel_ifid_flush", ifid_flush, 1);
        check("rel_bubble", idex_bubble, 1);
        check("rel_exmem_flush", exmem_flush, 1);
        check("rel_pc_write", pc_write, 1);
        check("rel_idex_hold", idex_hold, 0);
        tick();
        check("rel_hold_cnt", hold_cnt, 0);
        check("rel_state", state, 0);
        check("rel_flush_cnt", flush_cnt, 1);
        check("post_rel_flush", ifid_flush, 0);

        // Release without a branch falls through to load-use.
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        apply(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rel_lu_pc_write", pc_write, 0);
        check("rel_lu_bubble", idex_bubble, 1);
        check("rel_lu_flush", ifid_flush, 0);
        tick();
        check("rel_lu_stall_cnt", stall_cnt, 1);

        // Long hold: saturation at 255 and sticky timeout.
        do_reset();
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (255) tick();
        check("long_cnt_254", hold_cnt, 254);
        check("long_timeout_early", hold_timeout, 0);
        tick();
        check("long_cnt_255", hold_cnt, 255);
        check("long_timeout_set", hold_timeout, 1);
        repeat (4) tick();
        check("long_cnt_sat", hold_cnt, 255);
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("long_rel_cnt", hold_cnt, 0);
        check("long_rel_state", state, 0);
        check("long_rel_timeout", hold_timeout, 1);
        repeat (3) tick();
        check("long_timeout_sticky", hold_timeout, 1);
        do_reset();
        check("long_timeout_rst", hold_timeout, 0);

        // Reset mid-hold discards a pending branch.
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check("mid_state_hold", state, 1);
        rst = 1'b1;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_pc_write", pc_write, 1);
        check("mid_rst_idex_hold", idex_hold, 0);
        tick();
        rst = 1'b0;
        apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("mid_state", state, 0);
        check("mid_ifid_flush", ifid_flush, 0);
        check("mid_exmem_flush", exmem_flush, 0);
        check("mid_hold_cnt", hold_cnt, 0);
        check("mid_flush_cnt", flush_cnt, 0);
        check("mid_stall_cnt", stall_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
